// File: rtl/regfile_scoreboard.sv
// Two-write-port register file with same-cycle bypass,
// optional hardwired R0 and a per-register load scoreboard.
module regfile_scoreboard #(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_R0  = 1'b0,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rd_a_addr,
  input  logic [AW-1:0]     rd_b_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_a_busy,
  output logic              rd_b_busy,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic              wr_conflict
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                w0_ok;
  logic                w1_ok;
  logic                clash;

  function automatic logic [DATA_W-1:0] rd_mux(
    input logic [AW-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = regs[a];
    if (BYPASS) begin
      priority case (1'b1)
        w1_ok && (wr1_addr == a): v = wr1_data;
        w0_ok && (wr0_addr == a): v = wr0_data;
        default: ;
      endcase
    end
    if (ZERO_R0 && (a == '0)) v = '0;
    return v;
  endfunction

  // Effective write strobes: R0 writes vanish when hardwired,
  // and nothing forwards while reset holds the file cleared.
  always_comb begin
    w0_ok = wr0_en && !rst;
    w1_ok = wr1_en && !rst;
    if (ZERO_R0 && (wr0_addr == '0)) w0_ok = 1'b0;
    if (ZERO_R0 && (wr1_addr == '0)) w1_ok = 1'b0;
    clash = w0_ok && w1_ok && (wr0_addr == wr1_addr);
  end

  // Data store; wr1 is applied last so it wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (w0_ok) regs[wr0_addr] <= wr0_data;
      if (w1_ok) regs[wr1_addr] <= wr1_data;
    end
  end

  // Scoreboard next state: reserve beats a same-cycle clear.
  always_comb begin
    busy_nxt = busy_q;
    if (wr1_en) busy_nxt[wr1_addr] = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_R0) busy_nxt[0] = 1'b0;
  end

  // Scoreboard and collision flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy_q      <= busy_nxt;
      wr_conflict <= clash;
    end
  end

  // Combinational read ports; busy is never bypassed.
  always_comb begin
    rd_a_data = rd_mux(rd_a_addr);
    rd_b_data = rd_mux(rd_b_addr);
    rd_a_busy = busy_q[rd_a_addr];
    rd_b_busy = busy_q[rd_b_addr];
    busy_vec  = busy_q;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: three configurations share
// one stimulus stream, vectors checked through a queue.
module tb_regfile_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ra, rb;
  logic       w0e, w1e, rse;
  logic [2:0] w0a, w1a, rsa;
  logic [7:0] w0d, w1d;

  logic [7:0] m_a, m_b, n_a, n_b, z_a, z_b;
  logic       m_ab, m_bb, n_ab, n_bb, z_ab, z_bb;
  logic [7:0] m_bv, n_bv, z_bv;
  logic       m_cf, n_cf, z_cf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       w0e; logic [2:0] w0a; logic [7:0] w0d;
    logic       w1e; logic [2:0] w1a; logic [7:0] w1d;
    logic       rse; logic [2:0] rsa;
    logic [2:0] ra;  logic [2:0] rb;
    logic [7:0] ea;  logic [7:0] eb;  logic eba;
    logic [7:0] ebv; logic ecf;
    logic [7:0] ena;
    logic [7:0] eza; logic [7:0] ezbv; logic ezc;
  } vec_t;

  vec_t tbl [16];
  vec_t q [$];

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_W(8), .NUM_REGS(8), .BYPASS(1'b1), .ZERO_R0(1'b0)
  ) dut_m (
    .clk(clk), .rst(rst),
    .rd_a_addr(ra), .rd_b_addr(rb),
    .rd_a_data(m_a), .rd_b_data(m_b),
    .rd_a_busy(m_ab), .rd_b_busy(m_bb),
    .wr0_en(w0e), .wr0_addr(w0a), .wr0_data(w0d),
    .wr1_en(w1e), .wr1_addr(w1a), .wr1_data(w1d),
    .rsv_en(rse), .rsv_addr(rsa),
    .busy_vec(m_bv), .wr_conflict(m_cf)
  );

  regfile_scoreboard #(
    .DATA_W(8), .NUM_REGS(8), .BYPASS(1'b0), .ZERO_R0(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst),
    .rd_a_addr(ra), .rd_b_addr(rb),
    .rd_a_data(n_a), .rd_b_data(n_b),
    .rd_a_busy(n_ab), .rd_b_busy(n_bb),
    .wr0_en(w0e), .wr0_addr(w0a), .wr0_data(w0d),
    .wr1_en(w1e), .wr1_addr(w1a), .wr1_data(w1d),
    .rsv_en(rse), .rsv_addr(rsa),
    .busy_vec(n_bv), .wr_conflict(n_cf)
  );

  regfile_scoreboard #(
    .DATA_W(8), .NUM_REGS(8), .BYPASS(1'b1), .ZERO_R0(1'b1)
  ) dut_z (
    .clk(clk), .rst(rst),
    .rd_a_addr(ra), .rd_b_addr(rb),
    .rd_a_data(z_a), .rd_b_data(z_b),
    .rd_a_busy(z_ab), .rd_b_busy(z_bb),
    .wr0_en(w0e), .wr0_addr(w0a), .wr0_data(w0d),
    .wr1_en(w1e), .wr1_addr(w1a), .wr1_data(w1d),
    .rsv_en(rse), .rsv_addr(rsa),
    .busy_vec(z_bv), .wr_conflict(z_cf)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    w0e = 0; w0a = 0; w0d = 0;
    w1e = 0; w1a = 0; w1d = 0;
    rse = 0; rsa = 0;
  endtask

  initial begin
    logic [7:0] sa, sb, sna, sza;
    logic       sab;
    vec_t       e;

    // w0e,w0a,w0d, w1e,w1a,w1d, rse,rsa, ra,rb,
    // ea,eb,eba,ebv,ecf, ena, eza,ezbv,ezc
    tbl[0]  = '{1,1,'h11, 1,2,'h22, 0,0, 1,2,
                'h11,'h22,0,'h00,0, 'h00, 'h11,'h00,0};
    tbl[1]  = '{0,0,0, 0,0,0, 0,0, 1,2,
                'h11,'h22,0,'h00,0, 'h11, 'h11,'h00,0};
    tbl[2]  = '{1,5,'h0F, 1,5,'hF0, 0,0, 5,1,
                'hF0,'h11,0,'h00,1, 'h00, 'hF0,'h00,1};
    tbl[3]  = '{0,0,0, 0,0,0, 0,0, 5,5,
                'hF0,'hF0,0,'h00,0, 'hF0, 'hF0,'h00,0};
    tbl[4]  = '{1,4,'h3C, 0,0,0, 0,0, 4,3,
                'h3C,'h00,0,'h00,0, 'h00, 'h3C,'h00,0};
    tbl[5]  = '{0,0,0, 0,0,0, 1,6, 6,4,
                'h00,'h3C,0,'h40,0, 'h00, 'h00,'h40,0};
    tbl[6]  = '{0,0,0, 1,6,'h77, 1,6, 6,0,
                'h77,'h00,1,'h40,0, 'h00, 'h77,'h40,0};
    tbl[7]  = '{0,0,0, 1,6,'h78, 0,0, 6,0,
                'h78,'h00,1,'h00,0, 'h77, 'h78,'h00,0};
    tbl[8]  = '{0,0,0, 0,0,0, 0,0, 6,7,
                'h78,'h00,0,'h00,0, 'h78, 'h78,'h00,0};
    tbl[9]  = '{0,0,0, 1,7,'hAA, 1,3, 7,3,
                'hAA,'h00,0,'h08,0, 'h00, 'hAA,'h08,0};
    tbl[10] = '{1,3,'h55, 0,0,0, 1,3, 3,7,
                'h55,'hAA,1,'h08,0, 'h00, 'h55,'h08,0};
    tbl[11] = '{1,2,'h12, 1,3,'h33, 1,0, 3,2,
                'h33,'h12,1,'h01,0, 'h55, 'h33,'h00,0};
    tbl[12] = '{1,0,'h99, 1,0,'h66, 0,0, 0,3,
                'h66,'h33,1,'h00,1, 'h00, 'h00,'h00,0};
    tbl[13] = '{0,0,0, 0,0,0, 0,0, 0,2,
                'h66,'h12,0,'h00,0, 'h66, 'h00,'h00,0};
    tbl[14] = '{1,0,'hFF, 0,0,0, 1,0, 0,1,
                'hFF,'h11,0,'h01,0, 'h66, 'h00,'h00,0};
    tbl[15] = '{0,0,0, 0,0,0, 0,0, 0,6,
                'hFF,'h78,1,'h01,0, 'hFF, 'h00,'h00,0};

    // Reset: a write held during reset must stay invisible.
    rst = 1'b1;
    idle();
    ra = 0; rb = 0;
    w0e = 1; w0a = 3; w0d = 8'hA5;
    #2;
    for (int r = 0; r < 8; r++) begin
      ra = 3'(r);
      #1;
      chk($sformatf("rst_r%0d", r), m_a, 8'h00);
    end
    chk("rst_busy", m_bv, 8'h00);
    chk("rst_conf", m_cf, 1'b0);
    chk("rst_rdbusy", m_ab, 1'b0);
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      w0e = tbl[i].w0e; w0a = tbl[i].w0a; w0d = tbl[i].w0d;
      w1e = tbl[i].w1e; w1a = tbl[i].w1a; w1d = tbl[i].w1d;
      rse = tbl[i].rse; rsa = tbl[i].rsa;
      ra  = tbl[i].ra;  rb  = tbl[i].rb;
      q.push_back(tbl[i]);
      #2;
      sa = m_a; sb = m_b; sab = m_ab;
      sna = n_a; sza = z_a;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d_queue: got empty want entry", i);
      end else begin
        e = q.pop_front();
        chk($sformatf("v%0d_rda", i), sa, e.ea);
        chk($sformatf("v%0d_rdb", i), sb, e.eb);
        chk($sformatf("v%0d_abusy", i), sab, e.eba);
        chk($sformatf("v%0d_bvec", i), m_bv, e.ebv);
        chk($sformatf("v%0d_conf", i), m_cf, e.ecf);
        chk($sformatf("v%0d_nb_rda", i), sna, e.ena);
        chk($sformatf("v%0d_z_rda", i), sza, e.eza);
        chk($sformatf("v%0d_z_bvec", i), z_bv, e.ezbv);
        chk($sformatf("v%0d_z_conf", i), z_cf, e.ezc);
      end
    end

    // Collision on R4 plus reserve R7, then reset mid-cycle.
    @(negedge clk);
    idle();
    w0e = 1; w0a = 4; w0d = 8'h40;
    w1e = 1; w1a = 4; w1d = 8'h44;
    rse = 1; rsa = 7;
    ra = 4; rb = 7;
    @(posedge clk);
    #1;
    chk("pre_rst_rda", m_a, 8'h44);
    chk("pre_rst_bvec", m_bv, 8'h81);
    chk("pre_rst_conf", m_cf, 1'b1);
    chk("pre_rst_z_bvec", z_bv, 8'h80);
    chk("pre_rst_bbusy", m_bb, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_bvec", m_bv, 8'h00);
    chk("mid_rst_z_bvec", z_bv, 8'h00);
    chk("mid_rst_conf", m_cf, 1'b0);
    chk("mid_rst_z_conf", z_cf, 1'b0);
    chk("mid_rst_rda", m_a, 8'h00);
    chk("mid_rst_nb_rda", n_a, 8'h00);
    chk("mid_rst_bbusy", m_bb, 1'b0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_rda", m_a, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-port register file for the next-generation CPU datapath.
- Generalises the 4x4 file to DATA_W x NUM_REGS.
- Has two write ports: wr0 for ALU writeback and wr1 for load/memory writeback.
- Optional same-cycle write-to-read bypass, optional hardwired-zero R0, and a per-register busy scoreboard that the decoder uses to stall on pending loads.

Parameters:
- DATA_W, 4, register width in bits (≥1).
- NUM_REGS, 4, number of registers (≥2, power of two).
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = read returns stored value only.
- ZERO_R0, 0, 1 = R0 reads as 0, ignores writes and never goes busy.
- AW is a localparam, not overridable: AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_a_addr  in  AW  read port A address
- rd_b_addr  in  AW  read port B address
- rd_a_data  out  DATA_W  read port A data (combinational)
- rd_b_data  out  DATA_W  read port B data (combinational)
- rd_a_busy  out  1  scoreboard bit of rd_a_addr (combinational)
- rd_b_busy  out  1  scoreboard bit of rd_b_addr (combinational)
- wr0_en  in  1  ALU write enable
- wr0_addr  in  AW  ALU write address
- wr0_data  in  DATA_W  ALU write data
- wr1_en  in  1  load writeback enable; also clears busy
- wr1_addr  in  AW  load writeback address
- wr1_data  in  DATA_W  load writeback data
- rsv_en  in  1  reserve: set busy for rsv_addr (load issued)
- rsv_addr  in  AW  register to reserve
- busy_vec  out  NUM_REGS  all scoreboard bits, bit i = register i
- wr_conflict  out  1  registered flag: previous cycle had wr0_en & wr1_en to the same effective address

Behaviour:
- Reset (async, immediate):
  - all registers = 0, busy_vec = 0, wr_conflict = 0.
  - rd_*_data therefore reads 0 and rd_*_busy reads 0 while rst is high.
- Writes (posedge clk, rst low):
  - wr0_en writes wr0_data to wr0_addr; wr1_en writes wr1_data to wr1_addr.
  - Different addresses: both writes take effect in the same cycle.
  - Same address with both enables: wr1 wins and wr0 is dropped. wr_conflict = 1 on the following cycle only, otherwise 0.
- ZERO_R0=1:
  - writes to address 0 are discarded.
  - Reads of address 0 return 0 (including bypass) and busy[0] is held at 0.
  - A wr0/wr1 collision on address 0 does not set wr_conflict.
- Reads: combinational, no clock latency.
  - BYPASS=1: if rd_x_addr matches an enabled write this cycle, return that write data. If both writes match, return wr1_data. Otherwise return the stored value.
  - BYPASS=0: always return the stored value; the new value is visible the cycle after the write edge.
- Scoreboard (posedge clk), per register i:
  - rsv_en & rsv_addr==i → busy[i] set to 1. Takes priority over a same-cycle clear.
  - else wr1_en & wr1_addr==i → busy[i] cleared to 0.
  - wr0 never touches busy.
  - rsv on an already-busy register: stays 1 (idempotent).
  - wr1 to a non-busy register: writes data, busy stays 0.
- rd_x_busy is the stored busy bit (not bypassed). A register reserved at edge N reads busy from after edge N. The decoder stalls while busy = 1.
- The busy bit being cleared by wr1 and the data written by wr1 become visible together: BYPASS=1 gives the data same-cycle, but busy still reads 1 until the edge.
- Reset mid-operation: asynchronously clears all data and busy bits at once, and clears any pending wr_conflict. Nothing is preserved.
- Out-of-range addresses are impossible (NUM_REGS is a power of two).

Test Plan:
- Reset values, DATA_W=8, NUM_REGS=8: assert rst, then write 0xA5 to R3 and release.
  - R0..R7 read 0x00 before the write, and busy_vec=0x00.
- Dual write, different addresses:
  - wr0 R1=0x11 and wr1 R2=0x22 in the same cycle → next cycle R1=0x11, R2=0x22, wr_conflict=0.
- Same-address collision:
  - wr0 R5=0x0F and wr1 R5=0xF0 → R5=0xF0; wr_conflict=1 for exactly one cycle.
  - BYPASS=1: rd_a_addr=5 returns 0xF0 in the write cycle.
- Bypass off vs on, write R4=0x3C with rd_a_addr=4:
  - BYPASS=1 → rd_a_data=0x3C in the same cycle.
  - BYPASS=0 → old value in that cycle, 0x3C the next cycle.
- Scoreboard sequence:
  - rsv R6 → busy_vec=0x40.
  - rsv R6 plus wr1 R6=0x77 in the same cycle → busy stays 1, R6=0x77.
  - wr1 R6=0x78 alone → busy_vec=0x00, R6=0x78.
- ZERO_R0=1:
  - wr0 R0=0xFF plus rsv R0 → R0 reads 0x00 (including the same cycle), busy_vec[0]=0.
  - Assert rst while R7 is busy → busy_vec=0 immediately.
